// File: rtl/image_window_fetch.sv
// Raster-scans the frame, captures each 3x3 neighbourhood one cycle after its address is driven; scan stalls while out_valid && !out_ready.
// Build macro IMAGE_WINDOW_ZERO_PAD_EN: out-of-image neighbours read as 0 instead of edge-clamped values.
`timescale 1ns/1ps
module image_window_fetch #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 480,
    parameter int AW     = 18,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a1,
    output logic [AW-1:0] a2,
    output logic [AW-1:0] a3,
    output logic [AW-1:0] a4,
    output logic [AW-1:0] a5,
    output logic [AW-1:0] a6,
    output logic [AW-1:0] a7,
    output logic [AW-1:0] a8,
    output logic [AW-1:0] a9,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [DW-1:0] rd3,
    input  logic [DW-1:0] rd4,
    input  logic [DW-1:0] rd5,
    input  logic [DW-1:0] rd6,
    input  logic [DW-1:0] rd7,
    input  logic [DW-1:0] rd8,
    input  logic [DW-1:0] rd9,
    output logic [DW-1:0] win0,
    output logic [DW-1:0] win1,
    output logic [DW-1:0] win2,
    output logic [DW-1:0] win3,
    output logic [DW-1:0] win4,
    output logic [DW-1:0] win5,
    output logic [DW-1:0] win6,
    output logic [DW-1:0] win7,
    output logic [DW-1:0] win8,
    output logic [8:0]    out_x,
    output logic [8:0]    out_y,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [8:0]    x_q, x_d, y_q, y_d;
    logic [AW-1:0] rowbase_q, rowbase_d;
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];
    logic [8:0]    out_x_q, out_x_d, out_y_q, out_y_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          out_valid_q, out_valid_d;

    logic          x_first, x_last, y_first, y_last, adv;
    logic [8:0]    col [3];
    logic [AW-1:0] row [3];
    logic [AW-1:0] addr [9];
    logic [DW-1:0] rd [9];
    logic [DW-1:0] pix [9];

    assign x_first = (x_q == 9'd0);
    assign x_last  = (x_q == 9'(WIDTH - 1));
    assign y_first = (y_q == 9'd0);
    assign y_last  = (y_q == 9'(HEIGHT - 1));
    assign adv     = !out_valid_q || out_ready;

    assign rd[0] = rd1;
    assign rd[1] = rd2;
    assign rd[2] = rd3;
    assign rd[3] = rd4;
    assign rd[4] = rd5;
    assign rd[5] = rd6;
    assign rd[6] = rd7;
    assign rd[7] = rd8;
    assign rd[8] = rd9;

    // Neighbour rows come from rowbase by add/subtract, so no multiplier in the address path.
    always_comb begin
        col[0] = x_first ? x_q : x_q - 9'd1;
        col[1] = x_q;
        col[2] = x_last ? x_q : x_q + 9'd1;
        row[0] = y_first ? rowbase_q : rowbase_q - AW'(WIDTH);
        row[1] = rowbase_q;
        row[2] = y_last ? rowbase_q : rowbase_q + AW'(WIDTH);
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                addr[r*3+c] = '0;
                if (state_q == S_FETCH) begin
                    addr[r*3+c] = row[r] + AW'(col[c]);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            pix[k] = rd[k];
        end
`ifdef IMAGE_WINDOW_ZERO_PAD_EN
        for (int i = 0; i < 3; i++) begin
            if (y_first) pix[i]     = '0;
            if (y_last)  pix[6+i]   = '0;
            if (x_first) pix[3*i]   = '0;
            if (x_last)  pix[3*i+2] = '0;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (adv && x_last && y_last) state_d = S_FLUSH;
            S_FLUSH: if (out_valid_q && out_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Scan counters and window register
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        rowbase_d   = rowbase_q;
        win_d       = win_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d       = '0;
                    y_d       = '0;
                    rowbase_d = '0;
                end
            end
            S_FETCH: begin
                if (adv) begin
                    win_d       = pix;
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    out_addr_d  = rowbase_q + AW'(x_q);
                    out_valid_d = 1'b1;
                    if (x_last) begin
                        x_d = '0;
                        if (!y_last) begin
                            y_d       = y_q + 9'd1;
                            rowbase_d = rowbase_q + AW'(WIDTH);
                        end
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            rowbase_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            rowbase_q   <= rowbase_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
        end
    end

    assign a1 = addr[0];
    assign a2 = addr[1];
    assign a3 = addr[2];
    assign a4 = addr[3];
    assign a5 = addr[4];
    assign a6 = addr[5];
    assign a7 = addr[6];
    assign a8 = addr[7];
    assign a9 = addr[8];

    assign win0 = win_q[0];
    assign win1 = win_q[1];
    assign win2 = win_q[2];
    assign win3 = win_q[3];
    assign win4 = win_q[4];
    assign win5 = win_q[5];
    assign win6 = win_q[6];
    assign win7 = win_q[7];
    assign win8 = win_q[8];

    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_image_window_fetch.sv
// Directed bench for image_window_fetch on a 4x3 frame with ram[i] = i + 100.
`timescale 1ns/1ps
module tb_image_window_fetch;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid;
    logic [AW-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9, out_addr;
    logic [DW-1:0] rd1, rd2, rd3, rd4, rd5, rd6, rd7, rd8, rd9;
    logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic [8:0]    out_x, out_y;
    logic [DW-1:0] win [9];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int w_first [9] = '{100, 100, 101, 100, 100, 101, 104, 104, 105};
    int w_mid   [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
`ifdef IMAGE_WINDOW_ZERO_PAD_EN
    int w_00    [9] = '{0, 0, 0, 0, 100, 101, 0, 104, 105};
    int w_last  [9] = '{106, 107, 0, 110, 111, 0, 0, 0, 0};
`else
    int w_00    [9] = '{100, 100, 101, 100, 100, 101, 104, 104, 105};
    int w_last  [9] = '{106, 107, 107, 110, 111, 111, 110, 111, 111};
`endif

    image_window_fetch #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .rd4(rd4), .rd5(rd5), .rd6(rd6), .rd7(rd7), .rd8(rd8), .rd9(rd9),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .out_x(out_x), .out_y(out_y), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    assign rd1 = DW'(a1 + AW'(100));
    assign rd2 = DW'(a2 + AW'(100));
    assign rd3 = DW'(a3 + AW'(100));
    assign rd4 = DW'(a4 + AW'(100));
    assign rd5 = DW'(a5 + AW'(100));
    assign rd6 = DW'(a6 + AW'(100));
    assign rd7 = DW'(a7 + AW'(100));
    assign rd8 = DW'(a8 + AW'(100));
    assign rd9 = DW'(a9 + AW'(100));

    assign win[0] = win0;
    assign win[1] = win1;
    assign win[2] = win2;
    assign win[3] = win3;
    assign win[4] = win4;
    assign win[5] = win5;
    assign win[6] = win6;
    assign win[7] = win7;
    assign win[8] = win8;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_win(input string tag, input int exp [9]);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s[%0d]", tag, k), 32'(win[k]), 32'(exp[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference neighbour value for window slot k centred on (px,py)
    function automatic int model_pix(int px, int py, int k);
        int nx, ny;
        nx = px + (k % 3) - 1;
        ny = py + (k / 3) - 1;
`ifdef IMAGE_WINDOW_ZERO_PAD_EN
        if (nx < 0 || nx > W - 1 || ny < 0 || ny > H - 1) return 0;
`endif
        if (nx < 0) nx = 0;
        if (nx > W - 1) nx = W - 1;
        if (ny < 0) ny = 0;
        if (ny > H - 1) ny = H - 1;
        return ny * W + nx + 100;
    endfunction

    initial begin
        int xfers, done_cnt, stall, last_xfer;
        bit finished;

        step;
        step;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(out_addr), 0);
        check("rst_win4", 32'(win4), 0);
        check("rst_a1", 32'(a1), 0);

        // First window with the consumer stalled
        out_ready = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        check("t1_busy", 32'(busy), 1);
        check("t1_valid", 32'(out_valid), 0);
        step;
        check("t2_valid", 32'(out_valid), 1);
        check("t2_addr", 32'(out_addr), 0);
        check("t2_x", 32'(out_x), 0);
        check("t2_y", 32'(out_y), 0);
        check_win("win_0_0", w_00);

        // Full scan: stall 5 cycles at (1,1), pulse start mid-scan
        xfers = 0; done_cnt = 0; stall = 0; last_xfer = -10; finished = 1'b0;
        for (int c = 0; c < 200 && !finished; c++) begin
            start = (xfers == 3);
            if (out_valid && out_addr == 5 && stall < 5) begin
                out_ready = 1'b0;
                if (stall > 0) begin
                    check("stall_addr", 32'(out_addr), 5);
                    check("stall_win4", 32'(win4), 105);
                    check("stall_fetch_ptr", 32'(a5), 6);
                end
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("xfer_addr", 32'(out_addr), 32'(xfers));
                check("xfer_x", 32'(out_x), 32'(xfers % W));
                check("xfer_y", 32'(out_y), 32'(xfers / W));
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("xfer%0d_w%0d", xfers, k), 32'(win[k]),
                          32'(model_pix(xfers % W, xfers / W, k)));
                end
                if (xfers == 0)  check_win("win_0_0_clamp_ref", w_first[4] == 100 ? w_00 : w_first);
                if (xfers == 5)  check_win("win_1_1", w_mid);
                if (xfers == 11) check_win("win_3_2", w_last);
                xfers++;
                last_xfer = cyc;
            end
            step;
            if (done) begin
                done_cnt++;
                check("done_timing", 32'(cyc), 32'(last_xfer + 1));
                finished = 1'b1;
            end
        end
        start = 1'b0;
        check("scan_done_cnt", 32'(done_cnt), 1);
        check("scan_xfers", 32'(xfers), 12);
        check("scan_stall_cycles", 32'(stall), 5);
        check("done_valid", 32'(out_valid), 0);
        step;
        check("post_done_busy", 32'(busy), 0);
        check("post_done_done", 32'(done), 0);

        // Reset while the 6th window is held
        out_ready = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 50 && !finished; c++) begin
            if (out_valid && out_addr == 5) finished = 1'b1;
            else step;
        end
        check("rst_mid_reached", 32'(finished), 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_addr", 32'(out_addr), 0);
        for (int k = 0; k < 9; k++) check($sformatf("rst_mid_w%0d", k), 32'(win[k]), 0);
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) done_cnt++;
            step;
        end
        check("rst_mid_no_done", 32'(done_cnt), 0);

        start = 1'b1;
        step;
        start = 1'b0;
        step;
        check("restart_valid", 32'(out_valid), 1);
        check("restart_addr", 32'(out_addr), 0);
        check("restart_x", 32'(out_x), 0);
        check("restart_y", 32'(out_y), 0);
        check_win("restart_win", w_00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/image_window_fetch.md
# image_window_fetch

- Raster-scan front end for the image-processing datapath.
- Walks every pixel of the frame held in the image memory and drives nine read addresses per cycle for the 3x3 neighbourhood of the current pixel.
- Captures the nine 16-bit pixels into an output register and hands each window, with its centre coordinates and centre address, to the downstream filter through a valid/ready handshake.
- Sits directly upstream of the image memory's combinational read ports and feeds the compute stage.

## Interface
- WIDTH, 320, image width in pixels.
- HEIGHT, 480, image height in pixels.
- AW, 18, memory address width.
- DW, 16, pixel width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame scan; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame is finished.
- a1..a9  out  AW each  read addresses to memory ports 1..9.
- rd1..rd9  in  DW each  combinational read data from those ports.
- win0..win8  out  DW each  registered window; row-major from (x-1,y-1) to (x+1,y+1); win4 is the centre.
- out_x  out  9  centre column of the held window.
- out_y  out  9  centre row of the held window.
- out_addr  out  AW  centre address (y*WIDTH+x) of the held window, for write-back.
- out_valid  out  1  window register holds an unconsumed window.
- out_ready  in  1  downstream accepts the window.

## Operation
- Address mapping:
  - Port ak carries neighbour k-1 in row-major order.
  - Neighbour (nx,ny) maps to address ny*WIDTH+nx.
- Scan counters:
  - Registers x, y, and rowbase = y*WIDTH.
  - rowbase is updated incrementally (add WIDTH on row wrap); no multiplier.
  - Row rowbase-WIDTH and row rowbase+WIDTH are derived by add/subtract.
- Border handling: neighbour coordinates outside [0,WIDTH-1] x [0,HEIGHT-1] are clamped to the nearest edge.
- State machine:
  - IDLE: a1..a9 = 0. start=1 -> FETCH; x, y, rowbase cleared.
  - FETCH: addresses driven from x and y. Advance condition: adv = !out_valid || out_ready.
    - On adv: rd1..rd9 are loaded into win0..win8; out_x, out_y and out_addr are loaded; out_valid is set.
    - On adv: x increments. At x=WIDTH-1, x wraps to 0 and y increments.
    - If adv happens on pixel (WIDTH-1,HEIGHT-1) -> FLUSH.
    - Without adv: counters and window register hold.
  - FLUSH: no new capture. When out_valid && out_ready: out_valid clears -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Handshake rules:
  - A window transfers on a cycle with out_valid && out_ready.
  - win*, out_x, out_y and out_addr are stable while out_valid=1 && out_ready=0.
  - In FETCH, out_valid clears only if the register is consumed and no new capture happens in the same cycle (cannot occur).
- start while busy: ignored.
- Reset values:
  - state IDLE.
  - busy=0, done=0, out_valid=0.
  - x, y, rowbase, out_x, out_y, out_addr = 0.
  - win0..win8 = 0.
- Reset mid-scan: the scan is abandoned, all outputs return to their reset values, and no done pulse is produced.

## Timing
- start high in cycle t -> FETCH in t+1 -> out_valid=1 from t+2.
- With out_ready held high: one window per cycle; the frame completes WIDTH*HEIGHT cycles after entering FETCH.
- FLUSH lasts until the last window is accepted.
- done pulses the cycle after the last window transfers.
- Memory read path is combinational within one cycle: addresses are registered-derived and data is captured on the same edge.

## Configuration
- IMAGE_WINDOW_ZERO_PAD_EN:
  - Defined: out-of-image neighbours are output as 0 instead of clamped. Their address port still carries the clamped address.
  - Undefined: edge clamping only.
  - The handshake and the state machine are identical in both builds.

## Test plan
All cases use WIDTH=4, HEIGHT=3 and memory model ram[i]=i+100.
- Pixel (0,0), clamp build:
  - start -> first window is 100,100,101,100,100,101,104,104,105.
  - out_addr=0, out_valid=1 at t+2.
- Pixel (0,0), IMAGE_WINDOW_ZERO_PAD_EN build:
  - window 0,0,0,0,100,101,0,104,105.
- Full scan with out_ready=1:
  - 12 windows are transferred; out_addr runs 0..11.
  - Pixel (3,2) window is 106,107,107,110,111,111,110,111,111.
  - done pulses exactly once, one cycle after the 12th transfer; busy=0 the following cycle.
- Backpressure: out_ready=0 for 5 cycles at pixel (1,1):
  - window 100,101,102,104,105,106,108,109,110 is held unchanged.
  - Counters do not advance; no window is dropped or duplicated.
- Reset at the 6th window:
  - next cycle out_valid=0, busy=0, all window outputs 0.
  - No done pulse.
  - A new start restarts at (0,0).
- start pulsed while busy: no effect; the scan order and the total of 12 windows are unchanged.
